// File: rtl/mult_pkg.sv
// Shared definitions for the iterative multiplier: FSM state encoding and
// elaboration-time sizing helpers.
`timescale 1ns/1ps

package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // A counter must be at least one bit wide even when it only ever holds 0.
  function automatic int cnt_width(input int n_values);
    return (n_values <= 2) ? 1 : $clog2(n_values);
  endfunction

endpackage

// File: rtl/mult_pp_gen.sv
// Combinational partial-product generator: multiplicand times one K-bit digit
// of the multiplier, exact in WA+K bits.
`timescale 1ns/1ps

module mult_pp_gen #(
  parameter int WA = 21,
  parameter int K  = 1
) (
  input  logic [WA-1:0]   a,
  input  logic [K-1:0]    digit,
  output logic [WA+K-1:0] pp
);

  always_comb begin
    pp = {{K{1'b0}}, a} * {{WA{1'b0}}, digit};
  end

endmodule

// File: rtl/mult_seq_param.sv
// Iterative radix-2^K unsigned multiplier with start/busy/done handshake.
// Define MULT_ACC_EN to add the acc_clr port and multiply-accumulate results.
`timescale 1ns/1ps

module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WA        = 21,
  parameter int WB        = 21,
  parameter int K         = 1,
  parameter int ACC_GUARD = 3,
`ifdef MULT_ACC_EN
  localparam int RW = WA + WB + ACC_GUARD
`else
  // Guard bits only matter when results accumulate.
  localparam int RW = WA + WB + 0 * ACC_GUARD
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
`ifdef MULT_ACC_EN
  input  logic          acc_clr,
`endif
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result
);

  localparam int N_STEPS = ceil_div(WB, K);
  localparam int BW      = N_STEPS * K;   // multiplier zero-extended to whole digits
  localparam int PW      = WA + BW;
  localparam int CW      = cnt_width(N_STEPS);
  localparam int PPW     = WA + K;

  state_t          state;
  state_t          state_nxt;
  logic [WA-1:0]   a_q;
  logic [BW-1:0]   b_shift;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   partial_nxt;
  logic [CW-1:0]   cnt;
  logic [PPW-1:0]  pp;
  logic [RW-1:0]   result_nxt;
  logic            accept;
  logic            last_step;
`ifdef MULT_ACC_EN
  logic            acc_clr_q;
`endif

  assign accept    = start && (state != RUN);
  assign last_step = (state == RUN) && (cnt == CW'(N_STEPS - 1));

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // ---------------- datapath ----------------
  mult_pp_gen #(
    .WA (WA),
    .K  (K)
  ) u_pp_gen (
    .a     (a_q),
    .digit (b_shift[K-1:0]),
    .pp    (pp)
  );

  always_comb begin
    partial_nxt = partial + (PW'(pp) << (cnt * K));
`ifdef MULT_ACC_EN
    result_nxt  = (acc_clr_q ? '0 : result) + RW'(partial_nxt);
`else
    result_nxt  = RW'(partial_nxt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_shift   <= '0;
      partial   <= '0;
      cnt       <= '0;
      result    <= '0;
`ifdef MULT_ACC_EN
      acc_clr_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q       <= A;
        b_shift   <= BW'(B);
        partial   <= '0;
        cnt       <= '0;
`ifdef MULT_ACC_EN
        acc_clr_q <= acc_clr;
`endif
      end else if (state == RUN) begin
        partial   <= partial_nxt;
        b_shift   <= b_shift >> K;
        cnt       <= cnt + CW'(1);
      end
      // The final step's sum goes straight to result, on the edge done rises.
      if (last_step) result <= result_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Self-checking bench for mult_seq_param: one K=1 and one K=2 instance,
// directed and random operations against an arithmetic reference model.
`timescale 1ns/1ps

module tb_mult_seq_param;

  localparam int WA  = 21;
  localparam int WB  = 21;
`ifdef MULT_ACC_EN
  localparam int RW  = WA + WB + 3;
`else
  localparam int RW  = WA + WB;
`endif
  localparam int NS1 = 21;  // ceil(21/1)
  localparam int NS2 = 11;  // ceil(21/2)

  logic          clk = 1'b0;
  logic          rst;
  logic          start_v   [2];
  logic [WA-1:0] a_v       [2];
  logic [WB-1:0] b_v       [2];
  logic          acc_clr_v [2];
  wire  [1:0]    busy_w;
  wire  [1:0]    done_w;
  logic [RW-1:0] res1;
  logic [RW-1:0] res2;
  logic [RW-1:0] model_acc [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_param #(.WA(WA), .WB(WB), .K(1), .ACC_GUARD(3)) u_k1 (
    .clk     (clk),
    .rst     (rst),
    .start   (start_v[0]),
    .A       (a_v[0]),
    .B       (b_v[0]),
`ifdef MULT_ACC_EN
    .acc_clr (acc_clr_v[0]),
`endif
    .busy    (busy_w[0]),
    .done    (done_w[0]),
    .result  (res1)
  );

  mult_seq_param #(.WA(WA), .WB(WB), .K(2), .ACC_GUARD(3)) u_k2 (
    .clk     (clk),
    .rst     (rst),
    .start   (start_v[1]),
    .A       (a_v[1]),
    .B       (b_v[1]),
`ifdef MULT_ACC_EN
    .acc_clr (acc_clr_v[1]),
`endif
    .busy    (busy_w[1]),
    .done    (done_w[1]),
    .result  (res2)
  );

  function automatic logic [RW-1:0] get_res(input int s);
    return (s == 0) ? res1 : res2;
  endfunction

  // Reference: exact product, optionally added to the running accumulator.
  function automatic logic [RW-1:0] model(input int s, input logic [WA-1:0] a,
                                          input logic [WB-1:0] b, input logic clr);
    logic [63:0] prod;
    prod = 64'(a) * 64'(b);
`ifdef MULT_ACC_EN
    return (clr ? RW'(0) : model_acc[s]) + RW'(prod);
`else
    return RW'(prod) + RW'(0 * clr);
`endif
  endfunction

  // One complete operation on instance s, with latency/handshake/result checks.
  task automatic run_op(input int s, input logic [WA-1:0] a, input logic [WB-1:0] b,
                        input logic clr, output logic [RW-1:0] got);
    int ns;
    int lat;
    logic bad;
    logic [RW-1:0] exp;
    ns  = (s == 0) ? NS1 : NS2;
    exp = model(s, a, b, clr);
    @(negedge clk);
    start_v[s] = 1'b1; a_v[s] = a; b_v[s] = b; acc_clr_v[s] = clr;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    a_v[s] = WA'($urandom); b_v[s] = WB'($urandom); acc_clr_v[s] = 1'($urandom);
    lat = 0;
    bad = 1'b0;
    for (int i = 1; i <= ns + 3; i++) begin
      if (busy_w[s] !== 1'b1 || done_w[s] !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      if (done_w[s] === 1'b1) begin
        lat = i;
        break;
      end
    end
    got = get_res(s);
    checks++;
    if (lat != ns) begin
      errors++;
      $display("FAIL latency inst%0d a=%0h b=%0h: got %0d edges, expected %0d", s, a, b, lat, ns);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL busy_run inst%0d: busy/done wrong during RUN, expected busy=1 done=0", s);
    end
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL result inst%0d a=%0h b=%0h: got %0h, expected %0h", s, a, b, got, exp);
    end
    checks++;
    if (busy_w[s] !== 1'b0) begin
      errors++;
      $display("FAIL busy_done inst%0d: got busy=%0b in DONE cycle, expected 0", s, busy_w[s]);
    end
    @(posedge clk); #1;
    checks++;
    if (done_w[s] !== 1'b0 || get_res(s) !== exp) begin
      errors++;
      $display("FAIL done_pulse inst%0d: got done=%0b result=%0h, expected done=0 result=%0h",
               s, done_w[s], get_res(s), exp);
    end
    model_acc[s] = exp;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busy_w[s] !== 1'b0 || done_w[s] !== 1'b0 || get_res(s) !== '0) begin
        errors++;
        $display("FAIL reset inst%0d: got busy=%0b done=%0b result=%0h, expected 0/0/0",
                 s, busy_w[s], done_w[s], get_res(s));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_acc[0] = '0;
    model_acc[1] = '0;
  endtask

  task automatic test_k1_directed();
    logic [RW-1:0] got;
    run_op(0, 21'd2, 21'd10, 1'b1, got);
    checks++;
    if (got !== RW'(20)) begin
      errors++; $display("FAIL k1_2x10: got %0h, expected 14", got);
    end
    run_op(0, 21'h1FFFFF, 21'h1FFFFF, 1'b1, got);
    checks++;
    if (got !== RW'(64'h3FFFFC00001)) begin
      errors++; $display("FAIL k1_max: got %0h, expected 3ffffc00001", got);
    end
    run_op(0, 21'd0, 21'd5, 1'b1, got);
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL k1_zero: got %0h, expected 0", got);
    end
  endtask

  task automatic test_random();
    logic [RW-1:0] got;
    for (int i = 0; i < 8; i++) begin
      run_op(i % 2, WA'($urandom), WB'($urandom), 1'($urandom), got);
    end
    run_op(1, 21'h1FFFFF, 21'h1FFFFF, 1'b1, got);
  endtask

  task automatic test_back_to_back();
    logic [RW-1:0] got;
    int gap;
    run_op(1, 21'd3, 21'd7, 1'b1, got);
    // run_op leaves us one cycle past DONE; redo the first op so the second
    // start lands exactly in its DONE cycle.
    @(negedge clk);
    start_v[1] = 1'b1; a_v[1] = 21'd3; b_v[1] = 21'd7; acc_clr_v[1] = 1'b1;
    @(posedge clk); #1;
    start_v[1] = 1'b0;
    gap = 0;
    for (int i = 1; i <= NS2 + 3; i++) begin
      @(posedge clk); #1;
      if (done_w[1] === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap != NS2 || res2 !== RW'(21)) begin
      errors++;
      $display("FAIL b2b_first: got %0d edges result=%0h, expected %0d edges result=15", gap, res2, NS2);
    end
    // Second request while DONE is showing.
    start_v[1] = 1'b1; a_v[1] = 21'd4; b_v[1] = 21'd5; acc_clr_v[1] = 1'b1;
    gap = 0;
    for (int i = 1; i <= NS2 + 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        start_v[1] = 1'b0; a_v[1] = 21'd99; b_v[1] = 21'd77;
      end
      if (i == 4) begin
        start_v[1] = 1'b1; a_v[1] = 21'd7; b_v[1] = 21'd9; acc_clr_v[1] = 1'b0;
      end
      if (i == 5) start_v[1] = 1'b0;
      if (done_w[1] === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap != NS2 + 1) begin
      errors++; $display("FAIL b2b_gap: got %0d edges between done pulses, expected %0d", gap, NS2 + 1);
    end
    checks++;
    if (res2 !== RW'(20)) begin
      errors++; $display("FAIL b2b_second: got %0h, expected 14", res2);
    end
    model_acc[1] = RW'(20);
    gap = 0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk); #1;
      if (done_w[1] !== 1'b0 || busy_w[1] !== 1'b0) gap = i;
    end
    checks++;
    if (gap != 0) begin
      errors++; $display("FAIL ignored_start: got activity at cycle %0d after op, expected idle", gap);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 21'd12345; b_v[0] = 21'd678; acc_clr_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++; $display("FAIL mid_run_busy: got busy=%0b, expected 1", busy_w[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || res1 !== '0 || res2 !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: got busy=%0b done=%0b res1=%0h res2=%0h, expected all 0",
               busy_w[0], done_w[0], res1, res2);
    end
    rst = 1'b0;
    model_acc[0] = '0;
    model_acc[1] = '0;
    seen = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0) seen = i;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_done: got activity at cycle %0d after reset, expected none", seen);
    end
  endtask

`ifdef MULT_ACC_EN
  task automatic test_acc();
    logic [RW-1:0] got;
    run_op(0, 21'd3, 21'd4, 1'b1, got);
    checks++;
    if (got !== RW'(12)) begin
      errors++; $display("FAIL acc_first: got %0h, expected c", got);
    end
    run_op(0, 21'd5, 21'd6, 1'b0, got);
    checks++;
    if (got !== RW'(42)) begin
      errors++; $display("FAIL acc_sum: got %0h, expected 2a", got);
    end
    run_op(0, 21'd1, 21'd1, 1'b1, got);
    checks++;
    if (got !== RW'(1)) begin
      errors++; $display("FAIL acc_clear: got %0h, expected 1", got);
    end
    for (int i = 0; i < 4; i++) begin
      run_op(1, 21'h1FFFFF, 21'h1FFFFF, 1'b0, got);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0; a_v[s] = '0; b_v[s] = '0; acc_clr_v[s] = 1'b0;
      model_acc[s] = '0;
    end
    test_reset();
    test_k1_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MULT_ACC_EN
    test_acc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
